// File: rtl/powerup_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : powerup_ctrl
//  Description : Frame-rate controller for the power-pack. Requests packs from
//                the renderer, detects ball/pack overlap on frame ticks, and
//                holds the collected effect for a fixed number of frames.
//  Revision    : 1.0 - initial release
// ============================================================================
module powerup_ctrl #(
    parameter int WIDTH          = 20,
    parameter int HEIGHT         = 20,
    parameter int BALL_SIZE      = 16,
    parameter int EFFECT_FRAMES  = 600,
    parameter int RESPAWN_FRAMES = 300
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic        clear,
    input  logic [10:0] ball_x,
    input  logic [9:0]  ball_y,
    input  logic        ball_owner,
    input  logic [10:0] rx,
    input  logic [9:0]  ry,
    input  logic [1:0]  mode,
    output logic        spawn,
    output logic        eaten,
    output logic        effect_active,
    output logic [1:0]  effect_mode,
    output logic        effect_owner,
    output logic [9:0]  frames_left
);

    // Geometry constants widened one bit so the edge sums never wrap.
    localparam logic [11:0] c_pack_w    = 12'(WIDTH);
    localparam logic [10:0] c_pack_h    = 11'(HEIGHT);
    localparam logic [11:0] c_ball_w    = 12'(BALL_SIZE);
    localparam logic [10:0] c_ball_h    = 11'(BALL_SIZE);
    localparam logic [9:0]  c_effect    = 10'(EFFECT_FRAMES);
    localparam logic [9:0]  c_respawn   = 10'(RESPAWN_FRAMES);

    typedef enum logic [1:0] {
        S_WAIT   = 2'd0,
        S_SPAWN  = 2'd1,
        S_ARMED  = 2'd2,
        S_EFFECT = 2'd3
    } state_t;

    state_t      r_state;
    logic [9:0]  r_cnt;
    logic        r_spawn;
    logic        r_eaten;
    logic        r_active;
    logic [1:0]  r_mode;
    logic        r_owner;
    logic [9:0]  r_frames_left;

    logic [11:0] w_bx;
    logic [11:0] w_px;
    logic [10:0] w_by;
    logic [10:0] w_py;
    logic        w_overlap_x;
    logic        w_overlap_y;
    logic        w_pack_placed;
    logic        w_hit;

    assign w_bx = {1'b0, ball_x};
    assign w_px = {1'b0, rx};
    assign w_by = {1'b0, ball_y};
    assign w_py = {1'b0, ry};

    // Axis-aligned box overlap; a pack parked at the origin is never a hit.
    assign w_overlap_x   = (w_bx < (w_px + c_pack_w)) && ((w_bx + c_ball_w) > w_px);
    assign w_overlap_y   = (w_by < (w_py + c_pack_h)) && ((w_by + c_ball_h) > w_py);
    assign w_pack_placed = |{rx, ry};
    assign w_hit         = w_overlap_x && w_overlap_y && w_pack_placed;

    // Pack lifecycle: wait -> spawn -> armed -> effect -> wait, all outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_WAIT;
            r_cnt         <= c_respawn;
            r_spawn       <= 1'b0;
            r_eaten       <= 1'b0;
            r_active      <= 1'b0;
            r_mode        <= 2'b00;
            r_owner       <= 1'b0;
            r_frames_left <= 10'd0;
        end else begin
            r_spawn <= 1'b0;
            r_eaten <= 1'b0;
            case (r_state)
                S_WAIT: begin
                    if (frame_tick) begin
                        if (r_cnt == 10'd1) begin
                            r_state <= S_SPAWN;
                            r_spawn <= 1'b1;
                        end else if (r_cnt != 10'd0) begin
                            r_cnt <= r_cnt - 10'd1;
                        end
                    end
                end
                S_SPAWN: begin
                    // Renderer position becomes valid now; first test waits for the next tick.
                    r_state <= S_ARMED;
                end
                S_ARMED: begin
                    // Clear is ignored here: the pack stays on the field.
                    if (frame_tick && w_hit) begin
                        r_eaten       <= 1'b1;
                        r_active      <= 1'b1;
                        r_mode        <= mode;
                        r_owner       <= ball_owner;
                        r_frames_left <= c_effect;
                        r_state       <= S_EFFECT;
                    end
                end
                S_EFFECT: begin
                    if (clear) begin
                        // Point scored: end the effect without consuming a frame.
                        r_frames_left <= 10'd0;
                        r_active      <= 1'b0;
                        r_cnt         <= c_respawn;
                        r_state       <= S_WAIT;
                    end else if (frame_tick) begin
                        if (r_frames_left <= 10'd1) begin
                            r_frames_left <= 10'd0;
                            r_active      <= 1'b0;
                            r_cnt         <= c_respawn;
                            r_state       <= S_WAIT;
                        end else begin
                            r_frames_left <= r_frames_left - 10'd1;
                        end
                    end
                end
                default: begin
                    r_state <= S_WAIT;
                end
            endcase
        end
    end

    assign spawn         = r_spawn;
    assign eaten         = r_eaten;
    assign effect_active = r_active;
    assign effect_mode   = r_mode;
    assign effect_owner  = r_owner;
    assign frames_left   = r_frames_left;

endmodule
`default_nettype wire

// File: doc/powerup_ctrl.md
# powerup_ctrl

Frame-rate controller for the power-pack. It sits directly upstream and downstream of the power-pack renderer. It drives the renderer's `spawn` and `eaten` inputs, reads back the pack position and `mode`, and detects ball/pack overlap. It then holds the collected effect for a fixed number of frames for the paddle and game logic to consume.

## Interface
Parameters:
- `WIDTH`, 20, pack width in pixels; must match the renderer.
- `HEIGHT`, 20, pack height in pixels; must match the renderer.
- `BALL_SIZE`, 16, ball square side in pixels.
- `EFFECT_FRAMES`, 600, effect duration in frames (10 s at 60 Hz); range 1..1023.
- `RESPAWN_FRAMES`, 300, frames between effect end (or reset) and the next spawn; range 1..1023.

Ports:
- `clk`  in  1  system pixel clock; the only clock.
- `reset`  in  1  synchronous, active-high.
- `frame_tick`  in  1  one-cycle pulse per frame, asserted at vsync start.
- `clear`  in  1  one-cycle pulse on point scored; ends any effect early.
- `ball_x`  in  11  ball left edge.
- `ball_y`  in  10  ball top edge.
- `ball_owner`  in  1  paddle that last hit the ball (0 = left, 1 = right).
- `rx`  in  11  pack left edge, from the renderer.
- `ry`  in  10  pack top edge, from the renderer.
- `mode`  in  2  pack type from the renderer: 00 shrink, 01 boost, 10 idk, 11 shield.
- `spawn`  out  1  one-cycle pulse that requests a new pack.
- `eaten`  out  1  one-cycle pulse when the pack is collected.
- `effect_active`  out  1  effect in force.
- `effect_mode`  out  2  mode latched at collection.
- `effect_owner`  out  1  beneficiary paddle, latched at collection.
- `frames_left`  out  10  remaining effect frames; 0 when no effect is active.

## Operation
States:
- **WAIT.** Counter `cnt` counts down on each `frame_tick`. When a `frame_tick` arrives with `cnt == 1`, the block goes to SPAWN.
- **SPAWN.** Lasts one cycle. `spawn` = 1, then go to ARMED unconditionally.
- **ARMED.** Hit test runs only on cycles with `frame_tick` = 1 (hit test defined below).
  - On a hit: `eaten` = 1 that cycle.
  - On a hit, latch `effect_mode <= mode` and `effect_owner <= ball_owner`.
  - On a hit, load `frames_left <= EFFECT_FRAMES` and go to EFFECT.
- **EFFECT.** `effect_active` = 1. Each `frame_tick` decrements `frames_left`.
  - When the decrement takes `frames_left` from 1 to 0, `effect_active` drops.
  - On that same transition, load `cnt <= RESPAWN_FRAMES` and go to WAIT.

Hit test: all four comparisons below must be true, and `{rx, ry}` must be nonzero. The renderer parks the pack at (0,0) after `eaten`, so the (0,0) position is never a hit.
- `ball_x < rx + WIDTH`
- `ball_x + BALL_SIZE > rx`
- `ball_y < ry + HEIGHT`
- `ball_y + BALL_SIZE > ry`

Arithmetic rules:
- All additions are 12-bit for x and 11-bit for y, so they cannot wrap.
- `cnt` and `frames_left` are 10 bits and never underflow. They saturate at 0.

`clear`:
- In EFFECT: `frames_left <= 0`, `effect_active <= 0`, `cnt <= RESPAWN_FRAMES`, go to WAIT.
- In ARMED: ignored; the pack stays on the field.
- In WAIT or SPAWN: no effect.

Simultaneous events:
- `clear` together with `frame_tick` in EFFECT: `clear` wins; no decrement.
- `clear` together with a hit in ARMED: the hit is taken.
- `reset` has priority over everything.

## Timing
- Reset values:
  - state = WAIT, `cnt` = `RESPAWN_FRAMES`.
  - `spawn`, `eaten`, `effect_active`, `effect_owner` = 0.
  - `effect_mode` = 00, `frames_left` = 0.
- `reset` asserted mid-effect: the effect ends on the next edge and the respawn delay restarts.
- All outputs are registered.
- `spawn` is high exactly one cycle, on the cycle after the `frame_tick` that expires WAIT. The renderer's `mode`, `rx` and `ry` are valid from the cycle after `spawn`. The first hit test is on the next `frame_tick`, at least one frame later, so stale position is never tested.
- `eaten` and `effect_active` rise on the cycle after the hit `frame_tick`. `frames_left` = `EFFECT_FRAMES` on that same cycle.
- `eaten` never overlaps `spawn`. At most one of the two pulses occurs per frame.
- Effect length is exactly `EFFECT_FRAMES` `frame_tick`s.
- Spawn-to-spawn minimum after a collection = 1 (hit frame) + `EFFECT_FRAMES` + `RESPAWN_FRAMES` frames.

## Test plan
Use `EFFECT_FRAMES`=4 and `RESPAWN_FRAMES`=3 unless stated otherwise.
1. **Reset to spawn.** Release reset and pulse `frame_tick` 3 times. Required: `spawn` pulses once, one cycle after the third tick; all other outputs stay 0.
2. **Collection.** Set `rx`=300, `ry`=200, `mode`=11, `ball_owner`=1, `ball_x`=285, `ball_y`=190, then pulse `frame_tick`. Required: `eaten`=1 for one cycle; `effect_active`=1, `effect_mode`=11, `effect_owner`=1, `frames_left`=4. After 4 more ticks: `effect_active`=0, `frames_left`=0. After 3 further ticks: `spawn` pulses.
3. **Edge and near-miss.** With `rx`=300, `ball_x`=284 (the ball's right edge equals `rx`): no hit. With `ball_x`=319: hit. With `rx`=`ry`=0 and the ball at (0,0): no hit.
4. **Clear mid-effect.** Assert `clear` together with `frame_tick` at `frames_left`=2. Required: next cycle `effect_active`=0, `frames_left`=0, state WAIT; `spawn` follows 3 ticks later.
5. **Reset mid-effect.** Assert reset at `frames_left`=3. Required: all outputs at reset values next cycle; `spawn` follows 3 ticks after reset release.
6. **Max/saturation.** Use `EFFECT_FRAMES`=1023 and `rx`=2040 (12-bit add), with the ball at `ball_x`=2047. Required: hit detected; `frames_left` counts 1023 down to 0 with no wrap.
